fetch_decode_stage: RTL and testbench

- Parametrised IF/ID front end for the pipelined LEGv8 core: PC register, PC+step adder, instruction-memory address drive, main-control decode and a registered IF/ID boundary.
- Adds stall, flush and taken-branch redirect, a valid bit, an illegal-opcode flag and a fetch counter.
- Feeds the register-file/ALU stage; the instruction memory stays outside the block and is read combinationally.

---
 rtl/fd_pkg.sv | 34 +++
 rtl/main_decoder.sv | 28 ++
 rtl/fetch_decode_stage.sv | 90 +++++++++
 tb/tb_fetch_decode_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// Shared constants for the IF/ID front end: opcodes, control-bit indices, control words.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fd_pkg;

    // 11-bit opcodes taken from instruction bits [31:21]
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    // CBZ only fixes the upper 8 opcode bits; the low 3 belong to the immediate
    localparam logic [7:0]  OP_CBZ_PREFIX = 8'b10110100;

    // Bit positions inside the 9-bit control word
    localparam int CTRL_REG2LOC  = 8;
    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_REGWRITE = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    // Control words per instruction class
    localparam logic [8:0] CTRL_RFMT = 9'b000100010;
    localparam logic [8:0] CTRL_LDUR = 9'b011110000;
    localparam logic [8:0] CTRL_STUR = 9'b110001000;
    localparam logic [8:0] CTRL_CBZ  = 9'b100000101;
    localparam logic [8:0] CTRL_NONE = 9'b000000000;

endpackage

// File: rtl/main_decoder.sv
// Main control decode: opcode[10:0] -> 9-bit control word plus illegal flag.
// Latency: purely combinational.
// Backpressure: none.
// Ports: opcode (in, 11), ctrl (out, 9), illegal (out, 1).
module main_decoder
    import fd_pkg::*;
(
    input  logic [10:0] opcode,
    output logic [8:0]  ctrl,
    output logic        illegal
);

    always_comb begin
        ctrl    = CTRL_NONE;
        illegal = 1'b0;
        if (opcode[10:3] == OP_CBZ_PREFIX) begin
            ctrl = CTRL_CBZ;
        end else begin
            case (opcode)
                OP_ADD, OP_SUB, OP_AND, OP_ORR: ctrl = CTRL_RFMT;
                OP_LDUR:                        ctrl = CTRL_LDUR;
                OP_STUR:                        ctrl = CTRL_STUR;
                default:                        illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/fetch_decode_stage.sv
// IF/ID front end: PC register, fetch address drive, main decode, registered IF/ID slot.
// Latency: one cycle from imem_rdata to id_* outputs; imem_addr is combinational from PC.
// Backpressure: stall holds PC, IF/ID and counter; branch_taken redirects even under stall.
// Ports: clock, reset_n (sync, active-low); stall, flush, branch_taken, branch_target;
//        imem_addr/imem_rdata to instruction memory; id_valid, id_pc, id_pc_next,
//        id_instr, id_ctrl, id_illegal to the next stage; fetch_count of captured instructions.
module fetch_decode_stage
    import fd_pkg::*;
#(
    parameter int              ADDR_W   = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4,
    parameter int              CNT_W    = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_pc_next,
    output logic [INSTR_W-1:0] id_instr,
    output logic [8:0]         id_ctrl,
    output logic               id_illegal,
    output logic [CNT_W-1:0]   fetch_count
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus;
    logic [8:0]        dec_ctrl;
    logic              dec_illegal;

    // Modulo-2^ADDR_W add; wrap past all-ones is intentional and silent
    assign pc_plus   = pc + ADDR_W'(PC_STEP);
    assign imem_addr = pc;

    main_decoder u_main_decoder (
        .opcode  (imem_rdata[31:21]),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_pc_next  <= '0;
            id_instr    <= '0;
            id_ctrl     <= '0;
            id_illegal  <= 1'b0;
            fetch_count <= '0;
        end else if (branch_taken) begin
            // Redirect wins over stall: the wrong-path slot must not survive
            pc          <= branch_target;
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_pc_next  <= '0;
            id_instr    <= '0;
            id_ctrl     <= '0;
            id_illegal  <= 1'b0;
        end else if (flush) begin
            // Bubble into IF/ID; PC still advances unless the front end is stalled
            if (!stall) begin
                pc <= pc_plus;
            end
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_pc_next  <= '0;
            id_instr    <= '0;
            id_ctrl     <= '0;
            id_illegal  <= 1'b0;
        end else if (!stall) begin
            pc          <= pc_plus;
            id_valid    <= 1'b1;
            id_pc       <= pc;
            id_pc_next  <= pc_plus;
            id_instr    <= imem_rdata;
            id_ctrl     <= dec_ctrl;
            id_illegal  <= dec_illegal;
            fetch_count <= fetch_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage; a second instance exercises PC wrap.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: stall/flush/branch driven directly from the sequence below.
module tb_fetch_decode_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall, flush, branch_taken;
    logic [63:0] branch_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [63:0] id_pc, id_pc_next;
    logic [31:0] id_instr;
    logic [8:0]  id_ctrl;
    logic        id_illegal;
    logic [31:0] fetch_count;

    // Wrap instance: separate fetch inputs, held in normal flow
    logic [63:0] w_imem_addr;
    logic        w_id_valid;
    logic [63:0] w_id_pc, w_id_pc_next;
    logic [31:0] w_id_instr;
    logic [8:0]  w_id_ctrl;
    logic        w_id_illegal;
    logic [31:0] w_fetch_count;
    logic        w_zero = 1'b0;
    logic [63:0] w_target = 64'h0;
    logic [31:0] w_rdata = 32'h8B00_0000;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    fetch_decode_stage dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc_next(id_pc_next),
        .id_instr(id_instr), .id_ctrl(id_ctrl), .id_illegal(id_illegal),
        .fetch_count(fetch_count)
    );

    fetch_decode_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clock(clock), .reset_n(reset_n), .stall(w_zero), .flush(w_zero),
        .branch_taken(w_zero), .branch_target(w_target),
        .imem_addr(w_imem_addr), .imem_rdata(w_rdata),
        .id_valid(w_id_valid), .id_pc(w_id_pc), .id_pc_next(w_id_pc_next),
        .id_instr(w_id_instr), .id_ctrl(w_id_ctrl), .id_illegal(w_id_illegal),
        .fetch_count(w_fetch_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset with stall, flush and branch all asserted: reset must win
        reset_n = 1'b0; stall = 1'b1; flush = 1'b1; branch_taken = 1'b1;
        branch_target = 64'h100; imem_rdata = 32'hF840_0000;
        step(); step();
        check("rst_addr",   imem_addr, 64'h0);
        check("rst_valid",  64'(id_valid), 64'h0);
        check("rst_count",  64'(fetch_count), 64'h0);
        check("rst_ctrl",   64'(id_ctrl), 64'h0);
        check("rst_pc",     id_pc, 64'h0);
        check("rst_pcnext", id_pc_next, 64'h0);
        check("rst_instr",  64'(id_instr), 64'h0);
        check("rst_illeg",  64'(id_illegal), 64'h0);
        check("wrap_rst_addr", w_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);

        // LDUR at PC 0
        reset_n = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        imem_rdata = 32'hF840_0000;
        step();
        check("ldur_pc",     id_pc, 64'h0);
        check("ldur_pcnext", id_pc_next, 64'h4);
        check("ldur_ctrl",   64'(id_ctrl), 64'(9'b011110000));
        check("ldur_valid",  64'(id_valid), 64'h1);
        check("ldur_illeg",  64'(id_illegal), 64'h0);
        check("ldur_addr",   imem_addr, 64'h4);
        check("ldur_count",  64'(fetch_count), 64'h1);
        check("wrap_addr",   w_imem_addr, 64'h0);
        check("wrap_pcnext", w_id_pc_next, 64'h0);
        check("wrap_pc",     w_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // ADD at PC 4
        imem_rdata = 32'h8B00_0000;
        step();
        check("add_pc",    id_pc, 64'h4);
        check("add_ctrl",  64'(id_ctrl), 64'(9'b000100010));
        check("add_instr", 64'(id_instr), 64'h8B00_0000);
        check("add_addr",  imem_addr, 64'h8);
        check("add_count", 64'(fetch_count), 64'h2);

        // Stall three cycles at PC 8 with SUB presented
        stall = 1'b1; imem_rdata = 32'hCB00_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr",  imem_addr, 64'h8);
            check("stall_pc",    id_pc, 64'h4);
            check("stall_instr", 64'(id_instr), 64'h8B00_0000);
            check("stall_count", 64'(fetch_count), 64'h2);
        end
        stall = 1'b0;
        step();
        check("sub_pc",    id_pc, 64'h8);
        check("sub_ctrl",  64'(id_ctrl), 64'(9'b000100010));
        check("sub_count", 64'(fetch_count), 64'h3);
        check("sub_addr",  imem_addr, 64'hC);

        // Branch while stalled
        stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h100;
        step();
        check("br_addr",  imem_addr, 64'h100);
        check("br_valid", 64'(id_valid), 64'h0);
        check("br_count", 64'(fetch_count), 64'h3);
        check("br_pc",    id_pc, 64'h0);
        check("br_instr", 64'(id_instr), 64'h0);

        // Redirect to 0x10, then flush there
        stall = 1'b0; branch_target = 64'h10;
        step();
        check("br2_addr", imem_addr, 64'h10);
        branch_taken = 1'b0; flush = 1'b1;
        step();
        check("fl_valid", 64'(id_valid), 64'h0);
        check("fl_addr",  imem_addr, 64'h14);
        check("fl_count", 64'(fetch_count), 64'h3);

        // Illegal all-zero opcode is still captured and counted
        flush = 1'b0; imem_rdata = 32'h0000_0000;
        step();
        check("ill_illeg", 64'(id_illegal), 64'h1);
        check("ill_ctrl",  64'(id_ctrl), 64'h0);
        check("ill_valid", 64'(id_valid), 64'h1);
        check("ill_pc",    id_pc, 64'h14);
        check("ill_count", 64'(fetch_count), 64'h4);

        // STUR, CBZ (low opcode bits are don't-care), ORR, AND
        imem_rdata = 32'hF800_0000;
        step();
        check("stur_ctrl",  64'(id_ctrl), 64'(9'b110001000));
        check("stur_illeg", 64'(id_illegal), 64'h0);
        imem_rdata = 32'hB4FF_FFFF;
        step();
        check("cbz_ctrl",  64'(id_ctrl), 64'(9'b100000101));
        check("cbz_illeg", 64'(id_illegal), 64'h0);
        check("cbz_pc",    id_pc, 64'h1C);
        imem_rdata = 32'hAA00_0000;
        step();
        check("orr_ctrl", 64'(id_ctrl), 64'(9'b000100010));
        imem_rdata = 32'h8A00_0000;
        step();
        check("and_ctrl",  64'(id_ctrl), 64'(9'b000100010));
        check("and_count", 64'(fetch_count), 64'h8);
        check("and_addr",  imem_addr, 64'h28);

        // Flush together with stall: bubble, PC holds
        flush = 1'b1; stall = 1'b1;
        step();
        check("flst_valid", 64'(id_valid), 64'h0);
        check("flst_addr",  imem_addr, 64'h28);
        check("flst_ctrl",  64'(id_ctrl), 64'h0);
        check("flst_count", 64'(fetch_count), 64'h8);

        // Reset mid-stall/redirect
        flush = 1'b0; branch_taken = 1'b1; branch_target = 64'h200; reset_n = 1'b0;
        step();
        check("rst2_addr",  imem_addr, 64'h0);
        check("rst2_count", 64'(fetch_count), 64'h0);
        check("rst2_valid", 64'(id_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
